// File: rtl/i2s_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_if
// Stereo sample stream from the SPI-fed sample buffer into the I2S transmitter.
//   s_valid : source has a left/right pair on s_left/s_right
//   s_ready : transmitter FIFO can accept a pair this cycle
//   s_left  : left-channel sample, two's complement
//   s_right : right-channel sample, two's complement
// master = sample source, slave = i2s_tx.
// -----------------------------------------------------------------------------
interface i2s_tx_if #(
  parameter int DATA_WIDTH = 24
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_left;
  logic [DATA_WIDTH-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// Philips-format I2S master transmitter. Stereo pairs arrive on a valid/ready
// stream into a small frame FIFO; the block generates SCK (i2s_clk) and WS and
// shifts each channel out MSB-first, WS leading the channel MSB by one SCK.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous active-low reset (flushes the FIFO)
//   enable     : run request, sampled only at frame boundaries
//   s_if       : sample stream (slave side of i2s_tx_if)
//   fifo_level : frames currently stored
//   underrun   : one-clk pulse when a frame is due and the FIFO is empty
//   busy       : transmitter running
//   i2s_clk    : SCK, receiver samples on the rising edge
//   i2s_ws     : word select, 0 = left, 1 = right
//   i2s_sd     : serial data
// -----------------------------------------------------------------------------
module i2s_tx #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  i2s_tx_if.slave                          s_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             underrun,
  output logic                             busy,
  output logic                             i2s_clk,
  output logic                             i2s_ws,
  output logic                             i2s_sd
);

  localparam int FRAME_W  = 2 * SLOT_WIDTH;
  localparam int SAMPLE_W = 2 * DATA_WIDTH;
  localparam int PAD_W    = SLOT_WIDTH - DATA_WIDTH;
  localparam int BC_W     = $clog2(FRAME_W);
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BC_W-1:0]    BC_LAST    = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0]    BC_START   = BC_W'(FRAME_W - 2);
  localparam logic [BC_W-1:0]    WS_LO      = BC_W'(SLOT_WIDTH - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg, state_next;
  logic [DIV_W-1:0]     div_reg, div_next;
  logic [BC_W-1:0]      bc_reg, bc_next;
  logic [BC_W-1:0]      bc_inc;
  logic                 sck_reg, sck_next;
  logic                 ws_reg, ws_next;
  logic                 sd_reg, sd_next;
  logic                 underrun_reg, underrun_next;
  logic                 stop_reg, stop_next;
  logic [FRAME_W-1:0]   shreg_reg, shreg_next;

  // Frame FIFO storage and pointers
  logic [SAMPLE_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LEVEL_W-1:0]   level_reg;
  logic [SAMPLE_W-1:0]  rd_data;
  logic [FRAME_W-1:0]   load_frame;
  logic                 full, empty, push, pop;

  assign full    = (level_reg == LEVEL_FULL);
  assign empty   = (level_reg == '0);
  assign push    = s_if.s_valid && !full;
  assign rd_data = mem[rd_ptr_reg];

  // Frame image as it leaves the shifter: {left, pad, right, pad}, MSB first.
  // Shifting one bit per SCK then lines each bit up with its bit counter value.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
      assign load_frame[FRAME_W-1-gi]    = rd_data[SAMPLE_W-1-gi];
      assign load_frame[SLOT_WIDTH-1-gi] = rd_data[DATA_WIDTH-1-gi];
    end
    for (genvar gi = 0; gi < PAD_W; gi++) begin : g_pad
      assign load_frame[SLOT_WIDTH+gi] = 1'b0;
      assign load_frame[gi]            = 1'b0;
    end
  endgenerate

  assign bc_inc = (bc_reg == BC_LAST) ? '0 : bc_reg + BC_W'(1);

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    bc_next       = bc_reg;
    sck_next      = sck_reg;
    ws_next       = ws_reg;
    sd_next       = sd_reg;
    shreg_next    = shreg_reg;
    stop_next     = stop_reg;
    underrun_next = 1'b0;
    pop           = 1'b0;

    case (state_reg)
      IDLE: begin
        div_next  = '0;
        bc_next   = BC_START;
        sck_next  = 1'b0;
        ws_next   = 1'b1;
        sd_next   = 1'b0;
        stop_next = 1'b0;
        if (enable) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (stop_reg) begin
          // Last frame has shifted out its final bit: park the pins.
          state_next = IDLE;
          stop_next  = 1'b0;
          div_next   = '0;
          bc_next    = BC_START;
          sck_next   = 1'b0;
          ws_next    = 1'b1;
          sd_next    = 1'b0;
        end else if (div_reg == DIV_LAST) begin
          div_next = '0;
          sck_next = !sck_reg;
          if (sck_reg) begin
            // Falling SCK edge: advance one bit.
            bc_next = bc_inc;
            ws_next = (bc_inc >= WS_LO) && (bc_inc <= BC_START);
            if (bc_inc == BC_LAST) begin
              // Frame boundary: the only point where enable and the FIFO are looked at.
              sd_next = 1'b0;
              if (!enable) begin
                stop_next = 1'b1;
              end else if (!empty) begin
                pop        = 1'b1;
                shreg_next = load_frame;
              end else begin
                shreg_next    = '0;
                underrun_next = 1'b1;
              end
            end else begin
              sd_next    = shreg_reg[FRAME_W-1];
              shreg_next = {shreg_reg[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      bc_reg       <= BC_START;
      sck_reg      <= 1'b0;
      ws_reg       <= 1'b1;
      sd_reg       <= 1'b0;
      shreg_reg    <= '0;
      underrun_reg <= 1'b0;
      stop_reg     <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bc_reg       <= bc_next;
      sck_reg      <= sck_next;
      ws_reg       <= ws_next;
      sd_reg       <= sd_next;
      shreg_reg    <= shreg_next;
      underrun_reg <= underrun_next;
      stop_reg     <= stop_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_reg + LEVEL_W'(push) - LEVEL_W'(pop);
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_if.s_left, s_if.s_right};
    end
  end

  assign s_if.s_ready = !full;
  assign fifo_level   = level_reg;
  assign underrun     = underrun_reg;
  assign busy         = (state_reg == RUN);
  assign i2s_clk      = sck_reg;
  assign i2s_ws       = ws_reg;
  assign i2s_sd       = sd_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
// Directed bench for i2s_tx (CLK_DIV=2, 24-bit samples in 32-bit slots,
// 8-frame FIFO). A small I2S receiver samples SD/WS on each SCK rise and
// queues every completed slot as {channel, length, 32-bit slot word}.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] fifo_level;
  logic       underrun, busy, i2s_clk, i2s_ws, i2s_sd;

  i2s_tx_if #(.DATA_WIDTH(24)) bus ();

  i2s_tx #(
    .CLK_DIV(2), .DATA_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(bus),
    .fifo_level(fifo_level), .underrun(underrun), .busy(busy),
    .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receiver / monitors
  logic [40:0] slot_q[$];
  logic [31:0] rx_acc = '0;
  int          rx_cnt = 0;
  logic        rx_ws_prev = 1'b1;
  logic        rx_started = 1'b0;
  logic        sck_d = 1'b0;
  logic        ur_d = 1'b0;
  int          ur_cnt = 0;
  int          ur_long = 0;
  int          ur_gap = 0;
  int          ur_prev = 0;
  int          cyc = 0;
  int          sd_ones = 0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    ur_d  <= underrun;
    sck_d <= i2s_clk;
    if (underrun) begin
      ur_cnt  <= ur_cnt + 1;
      ur_gap  <= cyc - ur_prev;
      ur_prev <= cyc;
      if (ur_d) ur_long <= ur_long + 1;
    end
    if (busy && i2s_sd) sd_ones <= sd_ones + 1;
    if (!busy) begin
      // A stop leaves the right slot's final pad bit unsampled.
      if (rx_started && rx_ws_prev && rx_cnt == 31)
        slot_q.push_back({1'b1, 8'd32, rx_acc[30:0], 1'b0});
      rx_started <= 1'b0;
      rx_cnt     <= 0;
      rx_ws_prev <= 1'b1;
    end else if (i2s_clk && !sck_d) begin
      rx_acc <= {rx_acc[30:0], i2s_sd};
      if (i2s_ws != rx_ws_prev) begin
        if (rx_started)
          slot_q.push_back({rx_ws_prev, 8'(rx_cnt + 1), rx_acc[30:0], i2s_sd});
        rx_started <= 1'b1;
        rx_cnt     <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
      rx_ws_prev <= i2s_ws;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    bus.s_valid = 1'b1;
    bus.s_left  = l;
    bus.s_right = r;
    step(1);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_slots(input int target, input int budget, input string tag);
    int k = 0;
    while (slot_q.size() < target && k < budget) begin step(1); k++; end
    chk(tag, 64'(slot_q.size() >= target), 64'd1);
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int k = 0;
    while (busy !== val && k < budget) begin step(1); k++; end
    chk(tag, 64'(busy), 64'(val));
  endtask

  task automatic wait_level(input int val, input int budget, input string tag);
    int k = 0;
    while (int'(fifo_level) != val && k < budget) begin step(1); k++; end
    chk(tag, 64'(fifo_level), 64'(val));
  endtask

  task automatic wait_ur(input int target, input int budget, input string tag);
    int k = 0;
    while (ur_cnt < target && k < budget) begin step(1); k++; end
    chk(tag, 64'(ur_cnt >= target), 64'd1);
  endtask

  task automatic chk_slot(input string tag, input int idx, input logic ch, input logic [23:0] s);
    logic [40:0] obs;
    obs = (idx < slot_q.size()) ? slot_q[idx] : '1;
    chk(tag, 64'(obs), 64'({ch, 8'd32, s, 8'h00}));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sck"}, 64'(i2s_clk), 64'd0);
    chk({tag, "_ws"}, 64'(i2s_ws), 64'd1);
    chk({tag, "_sd"}, 64'(i2s_sd), 64'd0);
  endtask

  logic [23:0] tl[9];
  logic [23:0] tr[9];
  int base, ur_base, sd0;

  initial begin
    tl[0] = 24'h800000; tr[0] = 24'h7FFFFF;
    tl[1] = 24'h000001; tr[1] = 24'hFFFFFF;
    tl[2] = 24'h123456; tr[2] = 24'hABCDEF;
    tl[3] = 24'hFEDCBA; tr[3] = 24'h654321;
    tl[4] = 24'h0F0F0F; tr[4] = 24'hF0F0F0;
    tl[5] = 24'h000000; tr[5] = 24'h800001;
    tl[6] = 24'h7FFFFF; tr[6] = 24'h000002;
    tl[7] = 24'hC3C3C3; tr[7] = 24'h3C3C3C;
    tl[8] = 24'hDEADBE; tr[8] = 24'hEFCAFE;
    bus.s_valid = 1'b0;
    bus.s_left  = '0;
    bus.s_right = '0;

    // 1. Reset with inputs toggling, then one frame
    for (int i = 0; i < 4; i++) begin
      enable      = i[0];
      bus.s_valid = 1'b1;
      bus.s_left  = 24'($urandom);
      bus.s_right = 24'($urandom);
      step(1);
    end
    chk_idle("rst");
    chk("rst_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    rst_n = 1'b1; enable = 1'b0; bus.s_valid = 1'b0;
    step(1);
    push(24'hA5A5A5, 24'h5A5A5A);
    chk("t1_level1", 64'(fifo_level), 64'd1);
    enable = 1'b1;
    step(1);
    chk("t1_entry_busy", 64'(busy), 64'd1);
    chk("t1_entry_sck", 64'(i2s_clk), 64'd0);
    step(1);
    chk("t1_sck_c1", 64'(i2s_clk), 64'd0);
    step(1);
    chk("t1_first_rise", 64'(i2s_clk), 64'd1);
    chk("t1_ws_before_fall", 64'(i2s_ws), 64'd1);
    step(2);
    chk("t1_first_fall", 64'(i2s_clk), 64'd0);
    chk("t1_ws_fall", 64'(i2s_ws), 64'd0);
    chk("t1_pop_level", 64'(fifo_level), 64'd0);
    enable = 1'b0;
    wait_slots(2, 600, "t1_slots");
    chk_slot("t1_left", 0, 1'b0, 24'hA5A5A5);
    chk_slot("t1_right", 1, 1'b1, 24'h5A5A5A);
    wait_busy(1'b0, 400, "t1_stop");
    step(2);
    chk_idle("t1_idle");
    chk("t1_no_underrun", 64'(ur_cnt), 64'd0);

    // 2. Fill the FIFO while idle; the ninth pair must be refused
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2_ready%0d", i), 64'(bus.s_ready), 64'(i < 8));
      push(tl[i], tr[i]);
    end
    chk("t2_level_full", 64'(fifo_level), 64'd8);
    chk("t2_ready_full", 64'(bus.s_ready), 64'd0);
    chk("t2_idle_busy", 64'(busy), 64'd0);
    chk("t2_no_underrun", 64'(ur_cnt), 64'd0);

    // 4. Stream the eight stored frames back to back
    enable = 1'b1;
    wait_slots(17, 2600, "t4_slots_a");
    chk("t4_no_gap_underrun", 64'(ur_cnt), 64'd0);
    wait_slots(19, 600, "t4_slots_b");
    for (int i = 0; i < 8; i++) begin
      chk_slot($sformatf("t4_left%0d", i), 2 + 2 * i, 1'b0, tl[i]);
      chk_slot($sformatf("t4_right%0d", i), 3 + 2 * i, 1'b1, tr[i]);
    end
    chk_slot("t4_zero_after", 18, 1'b0, 24'h000000);
    chk("t4_level_empty", 64'(fifo_level), 64'd0);

    // 3. Running with an empty FIFO: periodic single-cycle underruns, SD held 0
    wait_ur(1, 100, "t3_ur1");
    sd0 = sd_ones;
    wait_ur(3, 700, "t3_ur3");
    step(2);
    chk("t3_ur_period", 64'(ur_gap), 64'd256);
    chk("t3_ur_width", 64'(ur_long), 64'd0);
    chk("t3_sd_zero", 64'(sd_ones - sd0), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    enable = 1'b0;
    wait_busy(1'b0, 400, "t3_stop");
    step(2);
    ur_base = ur_cnt;

    // 5. Drop enable mid left slot: frame completes, no further pop
    for (int i = 0; i < 6; i++) push(tl[i], tr[i]);
    chk("t5_level6", 64'(fifo_level), 64'd6);
    step(2);
    base = slot_q.size();
    enable = 1'b1;
    wait_level(5, 20, "t5_pop");
    step(40);
    enable = 1'b0;
    chk("t5_busy_mid", 64'(busy), 64'd1);
    wait_busy(1'b0, 400, "t5_stop");
    step(2);
    chk_idle("t5_idle");
    chk("t5_level_kept", 64'(fifo_level), 64'd5);
    chk_slot("t5_left", base, 1'b0, tl[0]);
    chk_slot("t5_right", base + 1, 1'b1, tr[0]);
    chk("t5_no_underrun", 64'(ur_cnt), 64'(ur_base));

    // 6. Reset mid right slot with five frames stored, then restart
    push(tl[6], tr[6]);
    chk("t6_level6", 64'(fifo_level), 64'd6);
    base = slot_q.size();
    enable = 1'b1;
    wait_level(5, 20, "t6_pop");
    step(180);
    chk("t6_level_mid", 64'(fifo_level), 64'd5);
    rst_n = 1'b0;
    enable = 1'b0;
    step(1);
    chk_idle("t6_rst");
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    chk("t6_rst_ready", 64'(bus.s_ready), 64'd1);
    chk("t6_rst_underrun", 64'(underrun), 64'd0);
    chk_slot("t6_left_before_rst", base, 1'b0, tl[1]);
    rst_n = 1'b1;
    step(3);
    base = slot_q.size();
    push(tl[7], tr[7]);
    chk("t6_level1", 64'(fifo_level), 64'd1);
    enable = 1'b1;
    step(3);
    chk("t6_restart_rise", 64'(i2s_clk), 64'd1);
    wait_level(0, 20, "t6_restart_pop");
    step(10);
    enable = 1'b0;
    wait_busy(1'b0, 400, "t6_stop");
    step(2);
    chk_slot("t6_left", base, 1'b0, tl[7]);
    chk_slot("t6_right", base + 1, 1'b1, tr[7]);
    chk("t6_no_underrun", 64'(ur_cnt), 64'(ur_base));
    chk_idle("t6_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Philips-format I2S master transmitter: the playback-side counterpart of the design's I2S capture path.
- Accepts stereo samples over a valid/ready stream into an internal FIFO.
- Generates i2s_clk and i2s_ws and serialises samples MSB-first on i2s_sd.
- Sits between the SPI-fed sample buffer and the on-board audio output/DAC pins.

Parameters:
- CLK_DIV, 16: clk cycles per i2s_clk half-period (16 at 100 MHz gives a 3.125 MHz SCK); legal range ≥2.
- DATA_WIDTH, 24: bits per channel sample.
- SLOT_WIDTH, 32: SCK cycles per channel slot; must be ≥ DATA_WIDTH. A frame is 2*SLOT_WIDTH bits.
- FIFO_DEPTH, 8: stereo frames buffered; power of two.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: synchronous, active-low reset.
- enable, input, 1: run request.
- s_valid, input, 1: sample pair valid.
- s_ready, output, 1: FIFO can accept (= !full).
- s_left, input, DATA_WIDTH: left sample, two's complement.
- s_right, input, DATA_WIDTH: right sample.
- fifo_level, output, $clog2(FIFO_DEPTH+1): frames stored.
- underrun, output, 1: one-clk pulse when a frame is due and the FIFO is empty.
- busy, output, 1: state == RUN.
- i2s_clk, output, 1: SCK.
- i2s_ws, output, 1: word select; 0 = left, 1 = right.
- i2s_sd, output, 1: serial data.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE; FIFO flushed; fifo_level=0; s_ready=1.
  - i2s_clk=0, i2s_ws=1, i2s_sd=0, underrun=0, busy=0.
- FIFO:
  - Push on s_valid&&s_ready, storing {s_left,s_right}.
  - Pop only at frame-load events.
  - Push and pop in the same cycle leaves fifo_level unchanged.
  - Full: s_ready=0 and s_valid is ignored.
  - fifo_level is registered and reflects the push/pop on the following cycle.
- States: IDLE, RUN.
- IDLE → RUN when enable=1:
  - On entry: div_cnt=0, bit counter bc=2*SLOT_WIDTH-2, i2s_ws=1, i2s_clk=0.
- RUN, SCK generation:
  - div_cnt counts 0..CLK_DIV-1; at terminal count it wraps and toggles i2s_clk.
  - A toggle 0→1 is a rise event; a toggle 1→0 is a fall event.
  - The first rise occurs CLK_DIV cycles after RUN entry. SCK is 50% duty.
- Each fall event, all updates registered in the same clk edge as the i2s_clk toggle:
  - bc := (bc+1) mod 2*SLOT_WIDTH.
  - i2s_ws := 1 if new bc ∈ [SLOT_WIDTH-1, 2*SLOT_WIDTH-2], else 0. WS therefore leads the channel MSB by one SCK.
  - i2s_sd for new bc:
    - bc < DATA_WIDTH: left[DATA_WIDTH-1-bc].
    - SLOT_WIDTH ≤ bc < SLOT_WIDTH+DATA_WIDTH: right[DATA_WIDTH-1-(bc-SLOT_WIDTH)].
    - Otherwise 0.
- Frame load, at the fall event where new bc = 2*SLOT_WIDTH-1:
  - FIFO non-empty: pop into the shift/hold register.
  - FIFO empty: load zeros and pulse underrun for exactly one clk.
  - A frame is never partially replaced.
- enable:
  - Sampled only at frame-load events.
  - enable=0 there: no pop, no underrun. Return to IDLE on the next clk; outputs go to reset idle values. FIFO contents are retained.
  - The in-flight frame always completes before stopping.
- Rise events change only i2s_clk. The receiver samples on the rise.
- rst_n low mid-frame: immediate IDLE and flush on that edge, regardless of state.

Test Plan (CLK_DIV=2, DATA_WIDTH=24, SLOT_WIDTH=32, FIFO_DEPTH=8):
1. Reset with pins toggling → i2s_clk=0, i2s_ws=1, i2s_sd=0, s_ready=1, fifo_level=0, busy=0. Then push 0xA5A5A5/0x5A5A5A and set enable=1:
   - First rise 2 clk after RUN entry.
   - ws falls at the 1st fall.
   - Sampling sd on 24 rises after the next fall decodes 0xA5A5A5; the 8 pad bits are 0.
   - Right slot decodes 0x5A5A5A.
   - ws high for exactly 32 SCK.
2. Push 9 frames with enable=0 → s_ready=0 after the 8th; fifo_level=8; the 9th frame is ignored; no underrun.
3. enable=1 with an empty FIFO → underrun single-cycle pulse at each frame load (every 64 SCK = 256 clk); sd constant 0.
4. Stream 0x800000/0x7FFFFF, then 0x000001/0xFFFFFF → bit-exact MSB-first decode on a bench receiver, with no frame gaps while the FIFO is non-empty.
5. Drop enable mid-left-slot → current frame finishes through bit 63; no pop; IDLE with i2s_clk=0, ws=1; the remaining fifo_level is unchanged.
6. Assert rst_n=0 mid-right-slot with fifo_level=5 → next clk: IDLE, fifo_level=0, outputs at reset values; re-enable restarts cleanly from the load point.
